imem_resp: RTL and testbench

IMEM_RESP -- requirements
Module: imem_resp

---
 rtl/imem_resp.sv | 129 ++++++++++++
 tb/tb_imem_resp.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_resp.sv
// Instruction memory with fixed-latency fetch responses and a streaming program loader.
// Latency: responses appear LATENCY cycles after the accepting edge, back-to-back at full rate.
// Backpressure: none; every fetch is accepted, and load words are taken whenever ld_valid is high in LOAD.
//
// Ports:
//   clk, rst             : single clock, asynchronous active-high reset
//   exIns_ren/addr       : fetch request (byte address), one per cycle
//   exIns_valid/in       : response strobe and instruction word (word holds while idle)
//   fetch_err            : high with exIns_valid when the fetch was misaligned or out of range
//   ld_start/valid/data  : program load stream into the memory
//   ld_ptr, ld_done      : current load word pointer, sticky "pointer wrapped" flag
module imem_resp #(
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 1,
  parameter logic [31:0] NOP     = 32'h0000_0013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     exIns_ren,
  input  logic [31:0]              exIns_addr,
  output logic                     exIns_valid,
  output logic [31:0]              exIns_in,
  output logic                     fetch_err,
  input  logic                     ld_start,
  input  logic                     ld_valid,
  input  logic [31:0]              ld_data,
  output logic [$clog2(DEPTH)-1:0] ld_ptr,
  output logic                     ld_done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, LOAD} ld_state_t;

  logic [31:0] mem [DEPTH];

  // ---------------- fetch path ----------------
  logic          req_err;
  logic [AW-1:0] req_idx;

  // Any set bit above the word index means the address is past the array.
  assign req_err = (exIns_addr[1:0] != 2'b00) || (exIns_addr[31:AW+2] != '0);
  assign req_idx = exIns_addr[AW+1:2];

  logic [LATENCY-1:0] pipe_vld;
  logic [LATENCY-1:0] pipe_err;
  logic [31:0]        pipe_dat [LATENCY];

  // Payload fields only advance alongside a valid entry, so the last stage
  // keeps the most recent response word on idle cycles. The memory read here
  // uses the pre-edge contents, which gives read-before-write for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      pipe_err <= '0;
      for (int i = 0; i < LATENCY; i++) pipe_dat[i] <= NOP;
    end else begin
      pipe_vld[0] <= exIns_ren;
      if (exIns_ren) begin
        pipe_err[0] <= req_err;
        pipe_dat[0] <= req_err ? NOP : mem[req_idx];
      end
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        if (pipe_vld[i-1]) begin
          pipe_err[i] <= pipe_err[i-1];
          pipe_dat[i] <= pipe_dat[i-1];
        end
      end
    end
  end

  assign exIns_valid = pipe_vld[LATENCY-1];
  assign fetch_err   = pipe_vld[LATENCY-1] & pipe_err[LATENCY-1];
  assign exIns_in    = pipe_dat[LATENCY-1];

  // ---------------- loader ----------------
  ld_state_t     state, state_nxt;
  logic [AW-1:0] ptr_nxt;
  logic          done_nxt;
  logic          mem_we;
  logic [AW-1:0] mem_widx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ld_ptr  <= '0;
      ld_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      ld_ptr  <= ptr_nxt;
      ld_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ld_ptr;
    done_nxt  = ld_done;
    mem_we    = 1'b0;
    mem_widx  = ld_ptr;
    if (ld_start) begin
      // A start restarts the load even mid-stream; a word arriving with it
      // lands at index 0.
      state_nxt = LOAD;
      ptr_nxt   = '0;
      done_nxt  = 1'b0;
      if (ld_valid) begin
        mem_we   = 1'b1;
        mem_widx = '0;
        ptr_nxt  = AW'(1);
      end
    end else if (state == LOAD && ld_valid) begin
      mem_we  = 1'b1;
      ptr_nxt = ld_ptr + AW'(1);
      if (ld_ptr == AW'(DEPTH - 1)) begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
    end
    // No writes while reset is held: the array itself is never cleared.
    if (rst) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_widx] <= ld_data;
  end

endmodule

// File: tb/tb_imem_resp.sv
module tb_imem_resp;

  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        exIns_ren;
  logic [31:0] exIns_addr;
  logic        ld_start;
  logic        ld_valid;
  logic [31:0] ld_data;

  logic        vld2, err2, vld3, err3;
  logic [31:0] dat2, dat3;
  logic [3:0]  ptr2, ptr3;
  logic        done2, done3;

  always #5 clk = ~clk;

  imem_resp #(.DEPTH(DEPTH), .LATENCY(2), .NOP(NOP)) u_l2 (
    .clk(clk), .rst(rst),
    .exIns_ren(exIns_ren), .exIns_addr(exIns_addr),
    .exIns_valid(vld2), .exIns_in(dat2), .fetch_err(err2),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ptr(ptr2), .ld_done(done2)
  );

  imem_resp #(.DEPTH(DEPTH), .LATENCY(3), .NOP(NOP)) u_l3 (
    .clk(clk), .rst(rst),
    .exIns_ren(exIns_ren), .exIns_addr(exIns_addr),
    .exIns_valid(vld3), .exIns_in(dat3), .fetch_err(err3),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ptr(ptr3), .ld_done(done3)
  );

  typedef struct {
    logic        vld;
    logic        err;
    logic [31:0] dat;
  } exp_t;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  bit          m_loading;
  int          m_ptr;
  bit          m_done;
  exp_t        q2[$];
  exp_t        q3[$];
  logic [31:0] last2, last3;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Applied right after each rising edge using the inputs that edge sampled.
  task automatic model_edge();
    exp_t e;
    e.vld = exIns_ren;
    e.err = 1'b0;
    e.dat = 32'h0;
    if (exIns_ren) begin
      e.err = (exIns_addr % 4 != 0) || (exIns_addr >= 32'(4 * DEPTH));
      e.dat = e.err ? NOP : m_mem[int'(exIns_addr / 4)];
    end
    q2.push_back(e);
    q3.push_back(e);
    if (ld_start) begin
      m_loading = 1'b1;
      m_ptr     = 0;
      m_done    = 1'b0;
      if (ld_valid) begin
        m_mem[0] = ld_data;
        m_ptr    = 1;
      end
    end else if (m_loading && ld_valid) begin
      m_mem[m_ptr] = ld_data;
      if (m_ptr == DEPTH - 1) begin
        m_ptr     = 0;
        m_done    = 1'b1;
        m_loading = 1'b0;
      end else begin
        m_ptr = m_ptr + 1;
      end
    end
  endtask

  task automatic step(input logic ren, input logic [31:0] addr, input logic st,
                      input logic lv, input logic [31:0] d);
    exIns_ren  = ren;
    exIns_addr = addr;
    ld_start   = st;
    ld_valid   = lv;
    ld_data    = d;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic fetch(input logic [31:0] addr);
    step(1'b1, addr, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic do_reset(input int n);
    rst       = 1'b1;
    exIns_ren = 1'b0;
    ld_start  = 1'b0;
    ld_valid  = 1'b0;
    q2.delete();
    q3.delete();
    last2     = NOP;
    last3     = NOP;
    m_loading = 1'b0;
    m_ptr     = 0;
    m_done    = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic mon(input int lat);
    exp_t        e;
    bit          have;
    logic        v, er;
    logic [31:0] d, last;
    if (lat == 2) begin
      v = vld2; er = err2; d = dat2; last = last2;
      have = (q2.size() >= 2);
      if (have) e = q2.pop_front();
    end else begin
      v = vld3; er = err3; d = dat3; last = last3;
      have = (q3.size() >= 3);
      if (have) e = q3.pop_front();
    end
    if (!have) begin
      e.vld = 1'b0; e.err = 1'b0; e.dat = 32'h0;
    end
    chk($sformatf("valid_L%0d", lat), {31'b0, v}, {31'b0, e.vld});
    if (e.vld) begin
      chk($sformatf("err_L%0d", lat), {31'b0, er}, {31'b0, e.err});
      chk($sformatf("data_L%0d", lat), d, e.dat);
      if (lat == 2) last2 = e.dat; else last3 = e.dat;
    end else begin
      chk($sformatf("idle_err_L%0d", lat), {31'b0, er}, 32'h0);
      chk($sformatf("hold_data_L%0d", lat), d, last);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid_L2", {31'b0, vld2}, 32'h0);
      chk("rst_valid_L3", {31'b0, vld3}, 32'h0);
      chk("rst_err_L2", {31'b0, err2}, 32'h0);
      chk("rst_data_L2", dat2, NOP);
      chk("rst_data_L3", dat3, NOP);
    end else begin
      mon(2);
      mon(3);
    end
    chk("ld_ptr_L2", {28'b0, ptr2}, 32'(m_ptr));
    chk("ld_ptr_L3", {28'b0, ptr3}, 32'(m_ptr));
    chk("ld_done_L2", {31'b0, done2}, {31'b0, m_done});
    chk("ld_done_L3", {31'b0, done3}, {31'b0, m_done});
  end

  logic [31:0] prog [4];

  initial begin
    prog[0] = 32'h0050_0093;
    prog[1] = 32'h0010_0113;
    prog[2] = 32'h0020_81B3;
    prog[3] = 32'h0000_006F;
    exIns_addr = 32'h0;
    ld_data    = 32'h0;
    do_reset(3);
    idle(2);

    // Short program load, then stay in LOAD with pointer at 4
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b1, prog[i]);
    idle(2);

    // Back-to-back fetches of the loaded words
    for (int i = 0; i < 4; i++) fetch(32'(4 * i));
    idle(4);

    // Rejected fetches and range boundary
    fetch(32'h6);
    fetch(32'hFFFF_FFFF);
    fetch(32'(4 * DEPTH));
    fetch(32'h1);
    fetch(32'hC);
    idle(4);

    // Full reload: start and first word together, pointer wraps, extra word ignored
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 32'h0, (i == 0), 1'b1, $urandom);
    step(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    idle(2);
    for (int i = 0; i < DEPTH; i++) fetch(32'(4 * i));
    fetch(32'(4 * DEPTH - 4));
    idle(4);

    // Same-cycle fetch and write of index 3, during a fetch-heavy load
    step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'(4 * i), 1'b0, 1'b1, $urandom);
    step(1'b1, 32'hC, 1'b0, 1'b1, 32'hCAFE_F00D);
    fetch(32'hC);
    for (int i = 4; i < DEPTH; i++) step(1'b1, 32'hC, 1'b0, 1'b1, $urandom);
    idle(4);

    // Randomized mix of fetches (valid, misaligned, out of range) and loads
    for (int n = 0; n < 400; n++) begin
      int          kind;
      logic [31:0] a;
      kind = $urandom_range(0, 7);
      if (kind <= 4)      a = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (kind == 5) a = ($urandom & 32'h3C) | 32'($urandom_range(1, 3));
      else if (kind == 6) a = $urandom | 32'(4 * DEPTH);
      else                a = 32'hFFFF_FFFF;
      step($urandom_range(0, 3) != 0, a, $urandom_range(0, 31) == 0,
           $urandom_range(0, 1) == 1, $urandom);
    end
    idle(4);

    // Reset with fetches in flight; memory survives
    fetch(32'h8);
    fetch(32'h4);
    do_reset(2);
    idle(3);
    for (int i = 0; i < DEPTH; i++) fetch(32'(4 * i));
    idle(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
